// File: rtl/frame_dispatcher_if.sv
// Frame dispatcher bus: ingress stream, destination side-band, egress stream and status.
interface frame_dispatcher_if #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_PORTS = 4
) ();
  logic                 in_tvalid;
  logic [DATA_W-1:0]    in_tdata;
  logic                 in_tlast;
  logic                 in_tready;
  logic                 in_abort;
  logic                 dest_valid;
  logic [NUM_PORTS-1:0] dest_mask;
  logic                 dest_drop;
  logic                 almost_full;
  logic                 out_tvalid;
  logic [DATA_W-1:0]    out_tdata;
  logic                 out_tlast;
  logic [NUM_PORTS-1:0] out_tdest;
  logic                 out_tready;
  logic [15:0]          fwd_count;
  logic [15:0]          drop_count;

  // Dispatcher side
  modport slave (
    input  in_tvalid, in_tdata, in_tlast, in_abort, dest_valid, dest_mask, dest_drop, out_tready,
    output in_tready, almost_full, out_tvalid, out_tdata, out_tlast, out_tdest, fwd_count,
           drop_count
  );

  // Upstream/downstream environment side
  modport master (
    output in_tvalid, in_tdata, in_tlast, in_abort, dest_valid, dest_mask, dest_drop, out_tready,
    input  in_tready, almost_full, out_tvalid, out_tdata, out_tlast, out_tdest, fwd_count,
           drop_count
  );
endinterface

// File: rtl/frame_dispatcher.sv
// Store-and-forward frame dispatcher: buffers whole frames in a circular byte RAM with a
// descriptor FIFO, then forwards each frame to its one-hot destination or discards it.
module frame_dispatcher #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH      = 2048,
  parameter int unsigned DESC_DEPTH = 8,
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned AF_THRESH  = 64
) (
  input logic               clk,
  input logic               reset,
  frame_dispatcher_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = $clog2(DESC_DEPTH);

  typedef logic [AW:0] ptr_t;
  typedef enum logic [1:0] {StIdle, StDiscard, StSend} state_e;

  // Storage
  logic [DATA_W-1:0]    mem [DEPTH];
  ptr_t                 desc_start [DESC_DEPTH];
  ptr_t                 desc_len   [DESC_DEPTH];
  logic [NUM_PORTS-1:0] desc_dest  [DESC_DEPTH];
  logic                 desc_drop  [DESC_DEPTH];

  // Write side state
  ptr_t                 wr_ptr_q, wr_ptr_d, start_ptr_q, start_ptr_d;
  logic                 shadow_vld_q, shadow_vld_d, shadow_drop_q, shadow_drop_d;
  logic [NUM_PORTS-1:0] shadow_dest_q, shadow_dest_d;
  logic [DW:0]          dwp_q, dwp_d, drp_q, drp_d;
  logic                 af_q, af_d;

  // Read side state
  state_e               state_q, state_d;
  ptr_t                 rd_ptr_q, rd_ptr_d, cur_start_q, cur_start_d, cur_len_q, cur_len_d;
  ptr_t                 fetch_ptr_q, fetch_ptr_d, fetch_rem_q, fetch_rem_d;
  logic [NUM_PORTS-1:0] cur_dest_q, cur_dest_d;
  logic                 pf_valid_q, pf_valid_d, pf_last_q, pf_last_d;
  logic [DATA_W-1:0]    pf_data_q;
  logic                 out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic [15:0]          fwd_cnt_q, fwd_cnt_d, drop_cnt_q, drop_cnt_d;

  // Combinational helpers
  ptr_t                 used, free_cnt, push_len, rd_addr;
  logic                 buf_full, desc_full, desc_empty, wr_accept, frame_active, abort_evt, push;
  logic                 eff_vld, eff_drop, push_drop, rd_issue, hs, pf_move, fwd_inc, drop_fsm;
  logic [NUM_PORTS-1:0] eff_dest, push_dest;
  logic [16:0]          fwd_sum, drop_sum;

  // Occupancy, flow control and write-side event decode
  always_comb begin
    used         = wr_ptr_q - rd_ptr_q;
    free_cnt     = ptr_t'(DEPTH) - used;
    buf_full     = (used == ptr_t'(DEPTH));
    desc_full    = ((dwp_q - drp_q) == (DW+1)'(DESC_DEPTH));
    desc_empty   = (dwp_q == drp_q);
    bus.in_tready = ~reset & ~buf_full & ~desc_full;
    wr_accept    = bus.in_tvalid & ~reset & ~buf_full & ~desc_full;
    // A beat arriving with the abort still counts as an in-progress frame.
    frame_active = (wr_ptr_q != start_ptr_q) | wr_accept;
    abort_evt    = bus.in_abort & frame_active;
    push         = wr_accept & bus.in_tlast & ~abort_evt;
    eff_vld      = bus.dest_valid | shadow_vld_q;
    eff_dest     = bus.dest_valid ? bus.dest_mask : shadow_dest_q;
    eff_drop     = bus.dest_valid ? bus.dest_drop : shadow_drop_q;
    // Missing destination info means the frame is dropped.
    push_drop    = ~eff_vld | eff_drop;
    push_dest    = eff_vld ? eff_dest : '0;
    push_len     = wr_ptr_q + ptr_t'(1) - start_ptr_q;
    af_d         = (free_cnt < ptr_t'(AF_THRESH)) | desc_full;
  end

  // Write pointer, frame start and destination shadow next-state
  always_comb begin
    wr_ptr_d      = wr_accept ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
    start_ptr_d   = start_ptr_q;
    dwp_d         = push ? dwp_q + (DW+1)'(1) : dwp_q;
    shadow_vld_d  = eff_vld;
    shadow_dest_d = eff_dest;
    shadow_drop_d = eff_drop;
    if (abort_evt || push) begin
      shadow_vld_d  = 1'b0;
      shadow_dest_d = '0;
      shadow_drop_d = 1'b0;
    end
    if (abort_evt) begin
      wr_ptr_d = start_ptr_q;
    end else if (push) begin
      start_ptr_d = wr_ptr_q + ptr_t'(1);
    end
  end

  // Read FSM, prefetch pipeline and egress register next-state
  always_comb begin
    hs          = out_valid_q & bus.out_tready;
    pf_move     = pf_valid_q & (~out_valid_q | hs);
    state_d     = state_q;
    cur_start_d = cur_start_q;
    cur_len_d   = cur_len_q;
    cur_dest_d  = cur_dest_q;
    fetch_ptr_d = fetch_ptr_q;
    fetch_rem_d = fetch_rem_q;
    pf_valid_d  = pf_move ? 1'b0 : pf_valid_q;
    pf_last_d   = pf_last_q;
    rd_issue    = 1'b0;
    rd_addr     = fetch_ptr_q;
    drp_d       = drp_q;
    rd_ptr_d    = hs ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
    fwd_inc     = 1'b0;
    drop_fsm    = 1'b0;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    if (pf_move) begin
      out_valid_d = 1'b1;
      out_last_d  = pf_last_q;
      out_data_d  = pf_data_q;
    end else if (hs) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    unique case (state_q)
      StIdle: begin
        if (!desc_empty) begin
          drp_d       = drp_q + (DW+1)'(1);
          cur_start_d = desc_start[drp_q[DW-1:0]];
          cur_len_d   = desc_len[drp_q[DW-1:0]];
          if (desc_drop[drp_q[DW-1:0]] || desc_dest[drp_q[DW-1:0]] == '0) begin
            state_d = StDiscard;
          end else begin
            // Issue the first read straight from the descriptor to save a cycle.
            state_d     = StSend;
            cur_dest_d  = desc_dest[drp_q[DW-1:0]];
            rd_issue    = 1'b1;
            rd_addr     = desc_start[drp_q[DW-1:0]];
            fetch_ptr_d = desc_start[drp_q[DW-1:0]] + ptr_t'(1);
            fetch_rem_d = desc_len[drp_q[DW-1:0]] - ptr_t'(1);
            pf_valid_d  = 1'b1;
            pf_last_d   = (desc_len[drp_q[DW-1:0]] == ptr_t'(1));
          end
        end
      end
      StDiscard: begin
        rd_ptr_d = cur_start_q + cur_len_q;
        drop_fsm = 1'b1;
        state_d  = StIdle;
      end
      StSend: begin
        if (fetch_rem_q != '0 && (!pf_valid_q || pf_move)) begin
          rd_issue    = 1'b1;
          fetch_ptr_d = fetch_ptr_q + ptr_t'(1);
          fetch_rem_d = fetch_rem_q - ptr_t'(1);
          pf_valid_d  = 1'b1;
          pf_last_d   = (fetch_rem_q == ptr_t'(1));
        end
        if (hs && out_last_q) begin
          fwd_inc = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Saturating statistics counters
  always_comb begin
    fwd_sum    = {1'b0, fwd_cnt_q} + 17'(fwd_inc);
    drop_sum   = {1'b0, drop_cnt_q} + 17'(drop_fsm) + 17'(abort_evt);
    fwd_cnt_d  = fwd_sum[16] ? 16'hFFFF : fwd_sum[15:0];
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // Data RAM, descriptor storage and prefetch register (no reset needed)
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_q[AW-1:0]] <= bus.in_tdata;
    end
    if (push) begin
      desc_start[dwp_q[DW-1:0]] <= start_ptr_q;
      desc_len[dwp_q[DW-1:0]]   <= push_len;
      desc_dest[dwp_q[DW-1:0]]  <= push_dest;
      desc_drop[dwp_q[DW-1:0]]  <= push_drop;
    end
    if (rd_issue) begin
      pf_data_q <= mem[rd_addr[AW-1:0]];
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      start_ptr_q   <= '0;
      shadow_vld_q  <= 1'b0;
      shadow_dest_q <= '0;
      shadow_drop_q <= 1'b0;
      dwp_q         <= '0;
      drp_q         <= '0;
      af_q          <= 1'b0;
      state_q       <= StIdle;
      rd_ptr_q      <= '0;
      cur_start_q   <= '0;
      cur_len_q     <= '0;
      cur_dest_q    <= '0;
      fetch_ptr_q   <= '0;
      fetch_rem_q   <= '0;
      pf_valid_q    <= 1'b0;
      pf_last_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_data_q    <= '0;
      fwd_cnt_q     <= '0;
      drop_cnt_q    <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      start_ptr_q   <= start_ptr_d;
      shadow_vld_q  <= shadow_vld_d;
      shadow_dest_q <= shadow_dest_d;
      shadow_drop_q <= shadow_drop_d;
      dwp_q         <= dwp_d;
      drp_q         <= drp_d;
      af_q          <= af_d;
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      cur_start_q   <= cur_start_d;
      cur_len_q     <= cur_len_d;
      cur_dest_q    <= cur_dest_d;
      fetch_ptr_q   <= fetch_ptr_d;
      fetch_rem_q   <= fetch_rem_d;
      pf_valid_q    <= pf_valid_d;
      pf_last_q     <= pf_last_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      out_data_q    <= out_data_d;
      fwd_cnt_q     <= fwd_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign bus.almost_full = af_q;
  assign bus.out_tvalid  = out_valid_q;
  assign bus.out_tdata   = out_data_q;
  assign bus.out_tlast   = out_last_q;
  assign bus.out_tdest   = cur_dest_q;
  assign bus.fwd_count   = fwd_cnt_q;
  assign bus.drop_count  = drop_cnt_q;
endmodule

// File: tb/tb_frame_dispatcher.sv
// Directed bench for frame_dispatcher: frame vector table plus multi-cycle corner sequences.
module tb_frame_dispatcher;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  frame_dispatcher_if #(.DATA_W(8), .NUM_PORTS(4)) bus ();

  frame_dispatcher #(
    .DATA_W(8), .DEPTH(2048), .DESC_DEPTH(8), .NUM_PORTS(4), .AF_THRESH(64)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int         len;
    logic [3:0] dest;
    logic       drop;
    logic       has_dest;
    logic       late;
    int         abort_at;
    logic       emit;
    int         exp_fwd;
    int         exp_drop;
  } vec_t;

  typedef struct packed {
    logic [3:0] dest;
    logic       last;
    logic [7:0] data;
  } beat_t;

  int    errors = 0;
  int    checks = 0;
  beat_t rx_q[$];
  int    stall_viol = 0;
  logic  stall_q = 1'b0;
  beat_t stall_b;

  // Egress monitor: collects handshaken beats and flags any change while stalled
  always @(negedge clk) begin
    beat_t cur;
    cur = {bus.out_tdest, bus.out_tlast, bus.out_tdata};
    if (stall_q && !(bus.out_tvalid && cur == stall_b)) stall_viol++;
    stall_q = bus.out_tvalid && !bus.out_tready;
    stall_b = cur;
    if (bus.out_tvalid && bus.out_tready) rx_q.push_back(cur);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [7:0] d, input logic last, input logic dv,
                           input logic [3:0] dm, input logic dd, input logic ab);
    bit got = 0;
    bus.in_tvalid  = 1'b1;
    bus.in_tdata   = d;
    bus.in_tlast   = last;
    bus.dest_valid = dv;
    bus.dest_mask  = dm;
    bus.dest_drop  = dd;
    bus.in_abort   = ab;
    for (int n = 0; n < 5000; n++) begin
      if (bus.in_tready) begin
        got = 1;
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!got) chk("in_tready_timeout", 0, 1);
    bus.in_tvalid  = 1'b0;
    bus.in_tlast   = 1'b0;
    bus.dest_valid = 1'b0;
    bus.in_abort   = 1'b0;
  endtask

  task automatic check_frame(input string name, input int len, input logic [3:0] dest,
                             input logic [7:0] base);
    int    bad = -1;
    beat_t b;
    logic [7:0] ed;
    chk({name, "_beats"}, rx_q.size(), len);
    for (int i = 0; i < len && i < rx_q.size(); i++) begin
      b  = rx_q[i];
      ed = base + 8'(i);
      if (b.data != ed || b.last != (i == len - 1) || b.dest != dest) begin
        bad = i;
        break;
      end
    end
    chk({name, "_first_bad_beat"}, bad, -1);
  endtask

  vec_t vecs[10];
  int   exp_wr;
  int   exp_fwd;
  int   exp_drop;

  initial begin
    int         af_at;
    int         filler;
    logic [7:0] base;
    logic       last, dv, dd, ab;
    logic [3:0] dm;

    vecs[0] = '{64, 4'b0010, 1'b0, 1'b1, 1'b0, -1, 1'b1, 1, 0};
    vecs[1] = '{5,  4'b0100, 1'b1, 1'b1, 1'b0, -1, 1'b0, 1, 1};
    vecs[2] = '{10, 4'b0001, 1'b0, 1'b1, 1'b0, -1, 1'b1, 2, 1};
    vecs[3] = '{60, 4'b0010, 1'b0, 1'b1, 1'b0, 29, 1'b0, 2, 2};
    vecs[4] = '{20, 4'b1000, 1'b0, 1'b1, 1'b0, -1, 1'b1, 3, 2};
    vecs[5] = '{7,  4'b0010, 1'b0, 1'b0, 1'b0, -1, 1'b0, 3, 3};
    vecs[6] = '{3,  4'b0000, 1'b0, 1'b1, 1'b0, -1, 1'b0, 3, 4};
    vecs[7] = '{1,  4'b0011, 1'b0, 1'b1, 1'b0, -1, 1'b1, 4, 4};
    vecs[8] = '{8,  4'b0100, 1'b0, 1'b1, 1'b0, 7,  1'b0, 4, 5};
    vecs[9] = '{4,  4'b0100, 1'b0, 1'b1, 1'b1, -1, 1'b1, 5, 5};

    reset          = 1'b1;
    bus.in_tvalid  = 1'b0;
    bus.in_tdata   = '0;
    bus.in_tlast   = 1'b0;
    bus.in_abort   = 1'b0;
    bus.dest_valid = 1'b0;
    bus.dest_mask  = '0;
    bus.dest_drop  = 1'b0;
    bus.out_tready = 1'b0;
    #1;
    chk("reset_in_tready", int'(bus.in_tready), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_tvalid", int'(bus.out_tvalid), 0);
    chk("reset_out_tlast", int'(bus.out_tlast), 0);
    chk("reset_out_tdata", int'(bus.out_tdata), 0);
    chk("reset_out_tdest", int'(bus.out_tdest), 0);
    chk("reset_almost_full", int'(bus.almost_full), 0);
    chk("reset_fwd_count", int'(bus.fwd_count), 0);
    chk("reset_drop_count", int'(bus.drop_count), 0);
    reset = 1'b0;
    #1;
    chk("post_reset_in_tready", int'(bus.in_tready), 1);
    wait_cycles(2);

    exp_wr = 0;
    for (int v = 0; v < 10; v++) begin
      rx_q.delete();
      bus.out_tready = 1'b1;
      base = 8'(v * 37 + 1);
      for (int i = 0; i < vecs[v].len; i++) begin
        last = (i == vecs[v].len - 1);
        ab   = (i == vecs[v].abort_at);
        dv   = vecs[v].has_dest && (i == 0 || (vecs[v].late && last));
        dm   = (vecs[v].late && i == 0) ? 4'b0001 : vecs[v].dest;
        dd   = (vecs[v].late && i == 0) ? 1'b1 : vecs[v].drop;
        push_beat(base + 8'(i), last, dv, dm, dd, ab);
        if (ab) break;
      end
      if (vecs[v].abort_at < 0) exp_wr += vecs[v].len;
      if (vecs[v].emit) begin
        // Pop happens the cycle after tlast; first beat two cycles after the pop.
        wait_cycles(1);
        chk($sformatf("v%0d_tvalid_pop_plus1", v), int'(bus.out_tvalid), 0);
        wait_cycles(1);
        chk($sformatf("v%0d_tvalid_pop_plus2", v), int'(bus.out_tvalid), 1);
      end
      wait_cycles(vecs[v].len + 10);
      check_frame($sformatf("v%0d", v), vecs[v].emit ? vecs[v].len : 0, vecs[v].dest, base);
      chk($sformatf("v%0d_fwd_count", v), int'(bus.fwd_count), vecs[v].exp_fwd);
      chk($sformatf("v%0d_drop_count", v), int'(bus.drop_count), vecs[v].exp_drop);
    end
    exp_fwd  = 5;
    exp_drop = 5;

    // Abort with no frame in progress is ignored
    bus.in_abort = 1'b1;
    wait_cycles(1);
    bus.in_abort = 1'b0;
    wait_cycles(3);
    chk("idle_abort_ignored", int'(bus.drop_count), exp_drop);

    // Fill the buffer with one DEPTH-byte frame while egress is stalled
    rx_q.delete();
    bus.out_tready = 1'b0;
    af_at = 0;
    for (int n = 1; n <= 2048; n++) begin
      push_beat(8'h5A + 8'(n - 1), n == 2048, n == 1, 4'b0010, 1'b0, 1'b0);
      if (af_at == 0 && bus.almost_full) af_at = n;
    end
    chk("full_almost_full_beat", af_at, 1986);
    chk("full_in_tready_low", int'(bus.in_tready), 0);
    wait_cycles(4);
    chk("full_in_tready_hold", int'(bus.in_tready), 0);
    chk("full_almost_full_hold", int'(bus.almost_full), 1);
    chk("full_stalled_tvalid", int'(bus.out_tvalid), 1);
    chk("full_stalled_tdata", int'(bus.out_tdata), 8'h5A);
    bus.out_tready = 1'b1;
    wait_cycles(1);
    chk("full_in_tready_return", int'(bus.in_tready), 1);
    wait_cycles(2048 + 10);
    check_frame("full", 2048, 4'b0010, 8'h5A);
    exp_fwd++;
    exp_wr += 2048;
    chk("full_fwd_count", int'(bus.fwd_count), exp_fwd);
    chk("full_stall_violations", stall_viol, 0);

    // Move the write pointer to 2040 with a dropped filler, then straddle the wrap
    filler = ((2040 - (exp_wr % 2048)) + 2048) % 2048;
    for (int i = 0; i < filler; i++) push_beat(8'(i), i == filler - 1, 1'b0, 4'b0, 1'b0, 1'b0);
    exp_drop++;
    wait_cycles(10);
    rx_q.delete();
    bus.out_tready = 1'b0;
    for (int i = 0; i < 16; i++) push_beat(8'hC0 + 8'(i), i == 15, i == 3, 4'b0010, 1'b0, 1'b0);
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      bus.out_tready = 1'($urandom_range(0, 1));
    end
    bus.out_tready = 1'b1;
    wait_cycles(30);
    check_frame("wrap", 16, 4'b0010, 8'hC0);
    exp_fwd++;
    chk("wrap_fwd_count", int'(bus.fwd_count), exp_fwd);
    chk("wrap_drop_count", int'(bus.drop_count), exp_drop);
    chk("wrap_stall_violations", stall_viol, 0);

    // Discard of a dropped frame coinciding with an abort counts both
    rx_q.delete();
    push_beat(8'h11, 1'b1, 1'b0, 4'b0, 1'b0, 1'b0);
    push_beat(8'h22, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
    push_beat(8'h33, 1'b0, 1'b0, 4'b0, 1'b0, 1'b1);
    exp_drop += 2;
    wait_cycles(10);
    chk("drop_abort_same_cycle", int'(bus.drop_count), exp_drop);
    chk("drop_abort_no_egress", rx_q.size(), 0);

    // tlast+abort every cycle drives drop_count into saturation
    bus.in_tvalid = 1'b1;
    bus.in_tlast  = 1'b1;
    bus.in_abort  = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    bus.in_tvalid = 1'b0;
    bus.in_tlast  = 1'b0;
    bus.in_abort  = 1'b0;
    wait_cycles(5);
    chk("sat_drop_count", int'(bus.drop_count), 16'hFFFF);
    chk("sat_fwd_count", int'(bus.fwd_count), exp_fwd);
    chk("sat_no_egress", rx_q.size(), 0);
    chk("sat_out_tvalid", int'(bus.out_tvalid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/frame_dispatcher.md
Name: frame_dispatcher

Overview:
- Store-and-forward stage directly downstream of the preliminary processor.
- Buffers each ingress frame's bytes in a circular byte RAM, together with that frame's destination and drop decision.
- Once a frame is complete, either forwards it on a single AXI-stream-style egress carrying a one-hot destination, or discards it without emitting anything.
- Provides backpressure and an almost-full indication back to the upstream input stage.

Parameters:
DATA_W, 8, stream data width in bits (one entry per beat)
DEPTH, 2048, byte-buffer entries; power of two
DESC_DEPTH, 8, descriptor FIFO entries; power of two
NUM_PORTS, 4, egress destination count (width of one-hot dest)
AF_THRESH, 64, almost_full asserts when free entries < AF_THRESH

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
in_tvalid  in  1  ingress beat valid
in_tdata  in  DATA_W  ingress beat data
in_tlast  in  1  last beat of frame
in_tready  out  1  ingress ready
in_abort  in  1  discard the frame currently being written (pulse)
dest_valid  in  1  dest/drop info for current ingress frame valid (pulse)
dest_mask  in  NUM_PORTS  one-hot (or multi-hot) destination
dest_drop  in  1  frame must be dropped (type-field check failed)
almost_full  out  1  free byte entries < AF_THRESH, or descriptor FIFO full
out_tvalid  out  1  egress beat valid
out_tdata  out  DATA_W  egress beat data
out_tlast  out  1  last beat of egress frame
out_tdest  out  NUM_PORTS  destination mask, constant for the whole frame
out_tready  in  1  egress ready
fwd_count  out  16  frames forwarded, saturating
drop_count  out  16  frames dropped/aborted, saturating

Behaviour:
- Reset (async assert, sync release): pointers, counters and descriptor FIFO cleared; FSM to IDLE.
- Output reset values: in_tready=0 during reset and 1 from the first cycle after; out_tvalid=0, out_tlast=0, out_tdata=0, out_tdest=0, almost_full=0, both counters=0.
- A reset mid-frame loses all buffered frames; no partial frame is ever emitted.

Write side:
- A beat is accepted when in_tvalid & in_tready. It is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- in_tready=0 when the byte buffer is full (wr_ptr - rd_ptr == DEPTH, using a DEPTH+1-bit pointer compare) or the descriptor FIFO is full.
- dest_valid latches dest_mask/dest_drop into a per-frame shadow. Only the last dest_valid pulse before or at the tlast beat counts. If no pulse arrives, the frame is treated as dest_drop=1.
- On an accepted tlast beat: push descriptor {start_ptr, length, dest, drop} and set start_ptr = next wr_ptr. length is a log2(DEPTH)+1-bit count; a 1-beat frame has length=1.
- in_abort (any cycle, including the same cycle as a beat): wr_ptr rewinds to start_ptr, the shadow clears, and drop_count increments.
  - Abort wins over a simultaneous tlast; no descriptor is pushed.
  - Abort while no frame is in progress (wr_ptr == start_ptr) is ignored; no count.
- A frame longer than DEPTH cannot complete: the buffer fills and in_tready stays 0. Upstream is required to abort on almost_full; this is not recovered internally.
- almost_full is registered, 1-cycle latency.

Read side FSM:
- IDLE:
  - Descriptor FIFO non-empty → pop it.
  - drop=1 or dest==0 → DISCARD.
  - Otherwise → SEND.
- DISCARD (1 cycle): rd_ptr = start_ptr + length; drop_count++; → IDLE.
- SEND:
  - RAM read latency is 1 cycle, with one prefetch register; out_tvalid first rises 2 cycles after the pop.
  - Beats advance on out_tvalid & out_tready; out_tdata/out_tlast/out_tdest stay stable while out_tvalid=1 and out_tready=0.
  - out_tlast is asserted on beat number length.
  - After the tlast handshake: rd_ptr updated, fwd_count++, → IDLE. Zero bubbles between beats when out_tready=1.
- The byte-buffer and descriptor space freed by the read side is visible to the write side the following cycle.
- Simultaneous read and write at wrap-around are legal; both pointers are independent modulo DEPTH.
- Counters saturate at 16'hFFFF. If a drop and an abort occur in the same cycle, drop_count adds 2 (saturating).

Test Plan:
- 64-byte frame, dest_valid with dest_mask=4'b0010, drop=0, out_tready=1 → 64 beats out, out_tdest=4'b0010 on every beat, out_tlast on beat 64 only, first out_tvalid 2 cycles after descriptor pop, fwd_count=1.
- Frame with dest_drop=1, followed by a 10-byte frame to dest 4'b0001 → no beats for the first frame, drop_count=1, second frame's 10 beats emitted intact.
- in_abort asserted on byte 30 of a 60-byte frame, then a new 20-byte frame → only the 20-byte frame is emitted, drop_count=1, wr_ptr equals its pre-abort start_ptr plus 20.
- DEPTH=2048, out_tready=0, stream 2048 bytes → in_tready falls after the 2048th beat; almost_full asserts once free < 64. Then out_tready=1 → in_tready returns the cycle after the first freed entry.
- Frames straddling pointer wrap (start_ptr=2040, length 16) with random out_tready → byte-exact data, out_tdata stable while stalled.
- tlast and in_abort in the same cycle → no descriptor pushed, no egress, drop_count=1; counter preloaded near 16'hFFFF saturates at 16'hFFFF.
